// File: rtl/stage_buffer.sv
// Elastic buffer between two pipeline stages on the give/get handshake.
// Circular storage of DEPTH entries with flush and optional empty pass-through.
module stage_buffer #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 2,
    parameter int PASSTHRU = 0
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       up_give_i,
    output logic                       up_get_o,
    input  logic [DATA_W-1:0]          up_data_i,
    output logic                       dn_give_o,
    input  logic                       dn_get_i,
    output logic [DATA_W-1:0]          dn_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              store;
    logic              take;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // up_get_o looks only at registered state so no get-chain forms across stages.
    assign empty     = (count == '0);
    assign bypass    = (PASSTHRU != 0) && empty;
    assign up_get_o  = (count < FULL_CNT);
    assign dn_give_o = !empty || (bypass && up_give_i);
    assign dn_data_o = bypass ? up_data_i : mem[rd_ptr];
    assign count_o   = count;

    assign push  = up_give_i && up_get_o;
    assign pop   = dn_give_o && dn_get_i;
    // A bypassed payload consumed in the same cycle never touches storage.
    assign store = push && !(bypass && dn_get_i);
    assign take  = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset_i || flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (store) wr_ptr <= next_ptr(wr_ptr);
            if (take)  rd_ptr <= next_ptr(rd_ptr);
            case ({store, take})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage has no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (store && !reset_i && !flush_i) mem[wr_ptr] <= up_data_i;
    end
endmodule

// File: tb/tb_stage_buffer.sv
// Bench for stage_buffer: three configurations share one stimulus stream and are
// compared every cycle against queue-based models, plus directed scenarios.
module tb_stage_buffer;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        flush_i;
    logic        up_give_i;
    logic        dn_get_i;
    logic [15:0] up_data_i;

    logic        up_get    [3];
    logic        dn_give   [3];
    logic [15:0] dn_data   [3];
    logic [1:0]  count     [3];

    int          depth_of  [3] = '{2, 3, 2};
    bit          pt_of     [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] mq        [3][$];
    logic [15:0] out_seq   [3][$];
    logic        acc       [3];
    logic        seen_give [3];
    logic [15:0] seen_data [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage_buffer #(.DATA_W(16), .DEPTH(2), .PASSTHRU(0)) u_d2 (
        .clk(clk), .reset_i(reset_i), .flush_i(flush_i),
        .up_give_i(up_give_i), .up_get_o(up_get[0]), .up_data_i(up_data_i),
        .dn_give_o(dn_give[0]), .dn_get_i(dn_get_i), .dn_data_o(dn_data[0]),
        .count_o(count[0]));

    stage_buffer #(.DATA_W(16), .DEPTH(3), .PASSTHRU(0)) u_d3 (
        .clk(clk), .reset_i(reset_i), .flush_i(flush_i),
        .up_give_i(up_give_i), .up_get_o(up_get[1]), .up_data_i(up_data_i),
        .dn_give_o(dn_give[1]), .dn_get_i(dn_get_i), .dn_data_o(dn_data[1]),
        .count_o(count[1]));

    stage_buffer #(.DATA_W(16), .DEPTH(2), .PASSTHRU(1)) u_pt (
        .clk(clk), .reset_i(reset_i), .flush_i(flush_i),
        .up_give_i(up_give_i), .up_get_o(up_get[2]), .up_data_i(up_data_i),
        .dn_give_o(dn_give[2]), .dn_get_i(dn_get_i), .dn_data_o(dn_data[2]),
        .count_o(count[2]));

    // One clock cycle: drive, compare all DUTs to their models at negedge, advance models.
    task automatic step(input logic give, input logic [15:0] data, input logic get,
                        input logic fl, input logic rst);
        int          sz;
        logic        e_give;
        logic [15:0] e_data;
        up_give_i = give;
        up_data_i = data;
        dn_get_i  = get;
        flush_i   = fl;
        reset_i   = rst;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sz     = mq[k].size();
            e_give = (sz != 0) || (pt_of[k] && give);
            e_data = (sz != 0) ? mq[k][0] : data;
            n_checks++;
            if (up_get[k] !== (sz < depth_of[k])) begin
                n_fail++;
                $display("FAIL model_up_get[%0d] t=%0t got=%b exp=%b", k, $time, up_get[k], sz < depth_of[k]);
            end
            n_checks++;
            if (dn_give[k] !== e_give) begin
                n_fail++;
                $display("FAIL model_dn_give[%0d] t=%0t got=%b exp=%b", k, $time, dn_give[k], e_give);
            end
            n_checks++;
            if (count[k] !== 2'(sz)) begin
                n_fail++;
                $display("FAIL model_count[%0d] t=%0t got=%0d exp=%0d", k, $time, count[k], sz);
            end
            n_checks++;
            if (int'(count[k]) > depth_of[k]) begin
                n_fail++;
                $display("FAIL count_bound[%0d] t=%0t got=%0d max=%0d", k, $time, count[k], depth_of[k]);
            end
            if (e_give) begin
                n_checks++;
                if (dn_data[k] !== e_data) begin
                    n_fail++;
                    $display("FAIL model_dn_data[%0d] t=%0t got=%h exp=%h", k, $time, dn_data[k], e_data);
                end
            end
            acc[k]       = give && (up_get[k] === 1'b1);
            seen_give[k] = dn_give[k];
            seen_data[k] = dn_data[k];
            if (dn_give[k] === 1'b1 && get && !fl && !rst) out_seq[k].push_back(dn_data[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            sz = mq[k].size();
            if (rst || fl) begin
                mq[k].delete();
            end else if (!(pt_of[k] && sz == 0 && give && get)) begin
                if (get && sz != 0) void'(mq[k].pop_front());
                if (give && sz < depth_of[k]) mq[k].push_back(data);
            end
        end
        #1;
    endtask

    task automatic clear_out();
        for (int k = 0; k < 3; k++) out_seq[k].delete();
    endtask

    task automatic test_reset();
        up_give_i = 1'b0;
        up_data_i = '0;
        dn_get_i  = 1'b0;
        flush_i   = 1'b0;
        reset_i   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        for (int k = 0; k < 3; k++) mq[k].delete();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (count[k] !== 2'd0) begin n_fail++; $display("FAIL reset_count[%0d] got=%0d exp=0", k, count[k]); end
            n_checks++;
            if (up_get[k] !== 1'b1) begin n_fail++; $display("FAIL reset_up_get[%0d] got=%b exp=1", k, up_get[k]); end
            n_checks++;
            if (dn_give[k] !== 1'b0) begin n_fail++; $display("FAIL reset_dn_give[%0d] got=%b exp=0", k, dn_give[k]); end
        end
    endtask

    task automatic test_fill_drain();
        step(0, 0, 0, 1, 0);
        clear_out();
        step(1, 16'h000A, 0, 0, 0);
        step(1, 16'h000B, 0, 0, 0);
        n_checks++;
        if (count[0] !== 2'd2) begin n_fail++; $display("FAIL fill_count got=%0d exp=2", count[0]); end
        n_checks++;
        if (up_get[0] !== 1'b0) begin n_fail++; $display("FAIL fill_up_get got=%b exp=0", up_get[0]); end
        step(1, 16'h000C, 0, 0, 0);
        n_checks++;
        if (acc[0] !== 1'b0) begin n_fail++; $display("FAIL full_reject got=%b exp=0", acc[0]); end
        repeat (4) step(0, 0, 1, 0, 0);
        n_checks++;
        if (out_seq[0].size() != 2 || out_seq[0][0] !== 16'h000A || out_seq[0][1] !== 16'h000B) begin
            n_fail++;
            $display("FAIL drain_order got_size=%0d exp_size=2 (A,B)", out_seq[0].size());
        end
        n_checks++;
        if (count[0] !== 2'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", count[0]); end
    endtask

    task automatic test_wrap();
        int   cur = 1;
        int   cyc = 0;
        int   max_cnt = 0;
        logic tog = 1'b1;
        step(0, 0, 0, 1, 0);
        clear_out();
        while (out_seq[1].size() < 20 && cyc < 200) begin
            step(cur <= 20, 16'(cur), tog, 0, 0);
            if (acc[1]) cur++;
            tog = !tog;
            if (int'(count[1]) > max_cnt) max_cnt = int'(count[1]);
            cyc++;
        end
        n_checks++;
        if (out_seq[1].size() != 20) begin
            n_fail++;
            $display("FAIL wrap_timeout got=%0d exp=20 outputs", out_seq[1].size());
        end else begin
            int bad = -1;
            for (int i = 0; i < 20; i++) if (bad < 0 && out_seq[1][i] !== 16'(i + 1)) bad = i;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL wrap_order idx=%0d got=%0d exp=%0d", bad, out_seq[1][bad], bad + 1);
            end
        end
        n_checks++;
        if (max_cnt > 3) begin n_fail++; $display("FAIL wrap_max_count got=%0d exp<=3", max_cnt); end
    endtask

    task automatic test_full_push_pop();
        step(0, 0, 0, 1, 0);
        step(1, 16'h0001, 0, 0, 0);
        step(1, 16'h0002, 0, 0, 0);
        clear_out();
        step(1, 16'h0003, 1, 0, 0);
        n_checks++;
        if (acc[0] !== 1'b0) begin n_fail++; $display("FAIL fpp_no_push got=%b exp=0", acc[0]); end
        n_checks++;
        if (count[0] !== 2'd1) begin n_fail++; $display("FAIL fpp_count got=%0d exp=1", count[0]); end
        step(1, 16'h0003, 0, 0, 0);
        n_checks++;
        if (acc[0] !== 1'b1) begin n_fail++; $display("FAIL fpp_next_push got=%b exp=1", acc[0]); end
        repeat (3) step(0, 0, 1, 0, 0);
        n_checks++;
        if (out_seq[0].size() != 3 || out_seq[0][0] !== 16'h0001 || out_seq[0][1] !== 16'h0002
            || out_seq[0][2] !== 16'h0003) begin
            n_fail++;
            $display("FAIL fpp_order got_size=%0d exp_size=3 (1,2,3)", out_seq[0].size());
        end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 1, 0);
        step(1, 16'h0011, 0, 0, 0);
        step(1, 16'h0022, 0, 0, 0);
        clear_out();
        step(1, 16'h0055, 0, 1, 0);
        n_checks++;
        if (count[0] !== 2'd0) begin n_fail++; $display("FAIL flush_count got=%0d exp=0", count[0]); end
        n_checks++;
        if (dn_give[0] !== 1'b0) begin n_fail++; $display("FAIL flush_dn_give got=%b exp=0", dn_give[0]); end
        repeat (4) step(0, 0, 1, 0, 0);
        n_checks++;
        if (out_seq[0].size() != 0) begin
            n_fail++;
            $display("FAIL flush_leak got=%0d items first=%h exp=0 items", out_seq[0].size(), out_seq[0][0]);
        end
    endtask

    task automatic test_passthru();
        step(0, 0, 0, 1, 0);
        step(1, 16'h1234, 1, 0, 0);
        n_checks++;
        if (seen_give[2] !== 1'b1 || seen_data[2] !== 16'h1234) begin
            n_fail++;
            $display("FAIL pt_same_cycle got=%b/%h exp=1/1234", seen_give[2], seen_data[2]);
        end
        n_checks++;
        if (count[2] !== 2'd0) begin n_fail++; $display("FAIL pt_consumed_count got=%0d exp=0", count[2]); end
        step(1, 16'h1234, 0, 0, 0);
        n_checks++;
        if (count[2] !== 2'd1) begin n_fail++; $display("FAIL pt_stored_count got=%0d exp=1", count[2]); end
        step(0, 16'h0000, 0, 0, 0);
        n_checks++;
        if (seen_give[2] !== 1'b1 || seen_data[2] !== 16'h1234) begin
            n_fail++;
            $display("FAIL pt_held got=%b/%h exp=1/1234", seen_give[2], seen_data[2]);
        end
    endtask

    task automatic test_reset_priority();
        step(0, 0, 0, 1, 0);
        step(1, 16'h0001, 0, 0, 0);
        step(1, 16'h0002, 0, 0, 0);
        step(1, 16'h0003, 1, 1, 1);
        up_give_i = 1'b0;
        #1;
        n_checks++;
        if (count[0] !== 2'd0 || up_get[0] !== 1'b1 || dn_give[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_prio got count=%0d up_get=%b dn_give=%b exp 0/1/0", count[0], up_get[0], dn_give[0]);
        end
        clear_out();
        step(1, 16'h0007, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        n_checks++;
        if (out_seq[0].size() < 1 || out_seq[0][0] !== 16'h0007) begin
            n_fail++;
            $display("FAIL rst_first_out got_size=%0d exp first=0007", out_seq[0].size());
        end
    endtask

    task automatic test_random();
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_push_pop();
        test_flush();
        test_passthru();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
